// File: rtl/stage_loader_if.sv
// Bundle of the loader's control, ROM read and brick RAM write signals.
// start is a request sampled only while busy=0; done is a one-cycle acknowledgement.
interface stage_loader_if #(
    parameter int COLS   = 10,
    parameter int TYPE_W = 3,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 9
);
    logic                     start;
    logic [1:0]               stage_sel;
    logic                     rom_enable;
    logic [ADDR_W-1:0]        rom_addr;
    logic [1:0]               rom_stage;
    logic [COLS*TYPE_W-1:0]   rom_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_row;
    logic [COLS*TYPE_W-1:0]   wr_data;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         brick_count;
    logic [1:0]               fsm_state;

    modport slave (
        input  start, stage_sel, rom_data,
        output rom_enable, rom_addr, rom_stage, wr_en, wr_row, wr_data,
               busy, done, brick_count, fsm_state
    );

    modport master (
        output start, stage_sel, rom_data,
        input  rom_enable, rom_addr, rom_stage, wr_en, wr_row, wr_data,
               busy, done, brick_count, fsm_state
    );
endinterface

// File: rtl/stage_loader.sv
// Copies one stage's ROM rows into the brick RAM and counts destructible bricks.
// ROM reads are issued one per cycle; each returned row is written one cycle later.
module stage_loader #(
    parameter int ROWS   = 30,
    parameter int COLS   = 10,
    parameter int TYPE_W = 3,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 9
) (
    input  logic           clock,
    input  logic           reset_n,
    stage_loader_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam int RB_W = $clog2(COLS + 1);

    logic [1:0]        state;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_row;
    logic [RB_W-1:0]   row_bricks;

    assign bus.fsm_state = state;

    // Empty (000) and indestructible (111) bricks do not count toward stage clear.
    always_comb begin
        row_bricks = '0;
        for (int c = 0; c < COLS; c++) begin
            if (bus.rom_data[c*TYPE_W +: TYPE_W] != '0 &&
                bus.rom_data[c*TYPE_W +: TYPE_W] != '1)
                row_bricks = row_bricks + RB_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rd_valid        <= 1'b0;
            rd_row          <= '0;
            bus.rom_enable  <= 1'b0;
            bus.rom_addr    <= '0;
            bus.rom_stage   <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_row      <= '0;
            bus.wr_data     <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.brick_count <= '0;
        end else begin
            // rd_valid marks the cycle in which rom_data holds the row read last cycle.
            rd_valid <= bus.rom_enable;
            if (bus.rom_enable)
                rd_row <= bus.rom_addr;

            if (rd_valid) begin
                bus.wr_en       <= 1'b1;
                bus.wr_row      <= rd_row;
                bus.wr_data     <= bus.rom_data;
                bus.brick_count <= bus.brick_count + CNT_W'(row_bricks);
            end else begin
                bus.wr_en <= 1'b0;
            end

            case (state)
                IDLE, FIN: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.rom_stage   <= bus.stage_sel;
                        bus.brick_count <= '0;
                        bus.rom_addr    <= '0;
                        bus.rom_enable  <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.rom_addr == ADDR_W'(ROWS - 1)) begin
                        bus.rom_enable <= 1'b0;
                        state          <= DRAIN;
                    end else begin
                        bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // The last row's write happens the cycle rd_valid is high here.
                    if (!rd_valid) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_loader.sv
// Bench for stage_loader: table-driven loads, corner-case sequences and random loads
// compared against a row-list model of the stage ROM.
module tb_stage_loader;

    localparam int ROWS = 30;
    localparam int DW   = 30;
    localparam int W    = 35;

    logic clock;
    logic reset_n;

    stage_loader_if bus ();

    stage_loader dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] rom [4][ROWS];

    always @(posedge clock) begin
        if (bus.rom_enable && bus.rom_addr < 5'(ROWS))
            bus.rom_data <= rom[bus.rom_stage][bus.rom_addr];
        else
            bus.rom_data <= {DW{1'bx}};
    end

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0] stage;
        int         exp_count;
        bit         noise;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_row(input logic [DW-1:0] d);
        int n = 0;
        for (int c = 0; c < 10; c++) begin
            logic [2:0] t = d[c*3 +: 3];
            if (t != 3'd0 && t != 3'd7) n++;
        end
        return n;
    endfunction

    function automatic int model_count(input logic [1:0] s);
        int n = 0;
        for (int r = 0; r < ROWS; r++) n += count_row(rom[s][r]);
        return n;
    endfunction

    function automatic logic [63:0] outs_packed();
        return 64'({bus.rom_enable, bus.rom_addr, bus.rom_stage, bus.wr_en, bus.wr_row,
                    bus.wr_data, bus.busy, bus.done, bus.brick_count});
    endfunction

    // Called right after the edge that accepted start; follows the load for 33 cycles.
    task automatic run_after_start(input logic [1:0] s, input int exp_cnt,
                                   input bit noise, input bit hold);
        int run = 0;
        logic [W-1:0] e;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) exp_q.push_back({5'(r), rom[s][r]});
        for (int n = 0; n <= 32; n++) begin
            @(negedge clock);
            if (hold) begin
                bus.start = 1'b1;
            end else if (noise && n <= 30) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.stage_sel = 2'($urandom_range(0, 3));
            end else begin
                bus.start = 1'b0;
            end
            chk("busy", bus.busy, n <= 31);
            chk("done", bus.done, n == 32);
            chk("rom_enable", bus.rom_enable, n <= 29);
            chk("rom_addr", bus.rom_addr, (n < 29) ? n : 29);
            chk("rom_stage", bus.rom_stage, s);
            chk("wr_en", bus.wr_en, n >= 2 && n <= 31);
            if (bus.wr_en) begin
                chk("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_row", bus.wr_row, e[W-1:DW]);
                    chk("wr_data", bus.wr_data, e[DW-1:0]);
                    run += count_row(e[DW-1:0]);
                end
            end
            chk("brick_count_run", bus.brick_count, run);
        end
        chk("brick_count_final", bus.brick_count, exp_cnt);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic start_load(input logic [1:0] s, input int exp_cnt,
                              input bit noise, input bit hold);
        @(negedge clock);
        bus.start     = 1'b1;
        bus.stage_sel = s;
        @(posedge clock);
        run_after_start(s, exp_cnt, noise, hold);
    endtask

    task automatic after_done(input int exp_cnt);
        @(negedge clock);
        chk("done_single", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("count_hold", bus.brick_count, exp_cnt);
    endtask

    task automatic fill_rom();
        logic [DW-1:0] d;
        rom[0][0] = '1;
        for (int r = 1; r < 29; r++) begin
            d = '0;
            d[(r % 10)*3 +: 3]       = 3'd1;
            d[((r + 3) % 10)*3 +: 3] = 3'd7;
            rom[0][r] = d;
        end
        rom[0][29] = '0;
        for (int r = 0; r < ROWS; r++) begin
            rom[1][r] = DW'($urandom);
            rom[2][r] = DW'($urandom);
        end
        d = '0;
        for (int c = 0; c < 10; c += 2) d[c*3 +: 3] = 3'd7;
        rom[3][0]  = d;
        rom[3][29] = '1;
        for (int r = 1; r < 29; r++) begin
            d = '0;
            if (r == 1 || r == 16 || r == 28) begin
                for (int c = 0; c < 10; c++) d[c*3 +: 3] = 3'(2 + c % 5);
            end else begin
                d[0 +: 3]  = 3'd3;
                d[15 +: 3] = 3'd7;
                d[27 +: 3] = 3'd5;
                if (r == 2) d[3 +: 3] = 3'd4;
            end
            rom[3][r] = d;
        end
    endtask

    initial begin
        bit found;
        int cnt1;

        bus.start     = 1'b0;
        bus.stage_sel = 2'd0;
        reset_n       = 1'b1;
        fill_rom();

        // Asynchronous reset, asserted mid-cycle.
        #3 reset_n = 1'b0;
        #1 chk("reset_async", outs_packed(), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_idle", outs_packed(), 0);
        end

        vecs[0] = '{stage: 2'd0, exp_count: 28, noise: 1'b0};
        vecs[1] = '{stage: 2'd3, exp_count: 81, noise: 1'b0};
        vecs[2] = '{stage: 2'd2, exp_count: model_count(2), noise: 1'b1};
        vecs[3] = '{stage: 2'd1, exp_count: model_count(1), noise: 1'b0};
        for (int i = 0; i < 4; i++) begin
            start_load(vecs[i].stage, vecs[i].exp_count, vecs[i].noise, 1'b0);
            after_done(vecs[i].exp_count);
        end

        // Reset after row 10 has been written aborts the load.
        @(negedge clock);
        bus.start = 1'b1;
        bus.stage_sel = 2'd3;
        @(negedge clock);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (bus.wr_en && bus.wr_row == 5'd10) found = 1'b1;
        end
        chk("row10_seen", found, 1);
        #2 reset_n = 1'b0;
        #1 chk("reset_midload", outs_packed(), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            chk("no_done_after_abort", {bus.done, bus.busy, bus.brick_count}, 0);
        end
        cnt1 = model_count(1);
        start_load(2'd1, cnt1, 1'b0, 1'b0);
        after_done(cnt1);

        // start held across the FIN cycle: second load follows immediately.
        start_load(2'd0, 28, 1'b0, 1'b1);
        @(posedge clock);
        run_after_start(2'd0, 28, 1'b0, 1'b0);
        after_done(28);

        for (int k = 0; k < 6; k++) begin
            logic [1:0] s;
            bit nz;
            s  = 2'($urandom_range(0, 3));
            nz = 1'($urandom_range(0, 1));
            start_load(s, model_count(s), nz, 1'b0);
            after_done(model_count(s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
